// File: rtl/cluster_pkg.sv
// Shared constants and types for the cluster unpacker slice.
package cluster_pkg;

    localparam int unsigned NUM_VFATS       = 24;
    localparam int unsigned STRIPS_PER_VFAT = 64;
    localparam int unsigned NUM_STRIPS      = 1536;
    localparam int unsigned NUM_CLUSTERS    = 8;
    localparam int unsigned ADDR_BITS       = 11;
    localparam int unsigned SIZE_BITS       = 3;
    localparam int unsigned CLUSTER_BITS    = 14;
    localparam int unsigned NUM_VFAT2       = NUM_STRIPS / 8;

    localparam logic [ADDR_BITS-1:0] INVALID_ADDR = 11'h7FF;

    // Cluster word: [13:11] size (strips minus one), [10:0] first strip address.
    typedef struct packed {
        logic [SIZE_BITS-1:0] size;
        logic [ADDR_BITS-1:0] addr;
    } cluster_t;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } unpack_state_t;

endpackage

// File: rtl/cluster_to_mask.sv
// Expands one cluster word into a strip mask and flags strips past the last one.
module cluster_to_mask
    import cluster_pkg::*;
(
    input  cluster_t              i_cluster,
    output logic [NUM_STRIPS-1:0] o_mask,
    output logic                  o_valid,
    output logic                  o_overrun
);

    localparam logic [NUM_STRIPS-1:0] MASK_ONE = NUM_STRIPS'(1);

    // Walk the up-to-eight strips; 12-bit sums never wrap back to strip 0.
    always_comb begin
        logic [11:0] w_strip;
        o_mask    = '0;
        o_overrun = 1'b0;
        w_strip   = '0;
        o_valid   = ({1'b0, i_cluster.addr} < 12'(NUM_STRIPS));
        for (int unsigned j = 0; j < 8; j++) begin
            w_strip = {1'b0, i_cluster.addr} + 12'(j);
            if (o_valid && (3'(j) <= i_cluster.size)) begin
                if (w_strip < 12'(NUM_STRIPS)) begin
                    o_mask = o_mask | (MASK_ONE << w_strip);
                end else begin
                    o_overrun = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cluster_unpacker.sv
// Decodes a frame of eight cluster words into a strip map, one cluster per cycle.
module cluster_unpacker
    import cluster_pkg::*;
(
    input  logic                       clock4x,
    input  logic                       global_reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CLUSTER_BITS-1:0]    cluster0,
    input  logic [CLUSTER_BITS-1:0]    cluster1,
    input  logic [CLUSTER_BITS-1:0]    cluster2,
    input  logic [CLUSTER_BITS-1:0]    cluster3,
    input  logic [CLUSTER_BITS-1:0]    cluster4,
    input  logic [CLUSTER_BITS-1:0]    cluster5,
    input  logic [CLUSTER_BITS-1:0]    cluster6,
    input  logic [CLUSTER_BITS-1:0]    cluster7,
    input  logic                       overflow_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_STRIPS-1:0]      sbits_out,
    output logic [NUM_VFAT2-1:0]       vfat2_sbits_out,
    output logic [3:0]                 n_clusters,
    output logic                       overflow_out,
    output logic                       range_err
);

    unpack_state_t         r_state;
    unpack_state_t         w_next_state;
    logic [2:0]            r_k;
    cluster_t              r_clusters [NUM_CLUSTERS];
    logic [NUM_STRIPS-1:0] r_map;
    logic [NUM_STRIPS-1:0] w_mask;
    logic [NUM_STRIPS-1:0] w_next_map;
    logic [NUM_VFAT2-1:0]  r_vfat2;
    logic [NUM_VFAT2-1:0]  w_next_vfat2;
    logic [3:0]            r_n;
    logic                  r_overflow;
    logic                  r_range_err;
    logic                  w_valid;
    logic                  w_overrun;
    cluster_t              w_cur;

    assign w_cur = r_clusters[r_k];

    cluster_to_mask u_cluster_to_mask (
        .i_cluster (w_cur),
        .o_mask    (w_mask),
        .o_valid   (w_valid),
        .o_overrun (w_overrun)
    );

    // State register.
    always_ff @(posedge clock4x) begin
        if (!global_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept in IDLE, eight DECODE cycles, hold in DONE until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_next_state = DECODE;
            DECODE:  if (r_k == 3'd7)    w_next_state = DONE;
            DONE:    if (out_ready)      w_next_state = IDLE;
            default:                     w_next_state = IDLE;
        endcase
    end

    // Merge the current cluster and derive the VFAT2 summary from the merged map,
    // so the registered summary always matches the registered map.
    always_comb begin
        w_next_map   = r_map | w_mask;
        w_next_vfat2 = '0;
        for (int unsigned v = 0; v < NUM_VFAT2; v++) begin
            w_next_vfat2[v] = |w_next_map[v*8 +: 8];
        end
    end

    // Frame capture and per-cycle accumulation.
    always_ff @(posedge clock4x) begin
        if (!global_reset_n) begin
            r_k         <= '0;
            r_clusters  <= '{default: '0};
            r_map       <= '0;
            r_vfat2     <= '0;
            r_n         <= '0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_clusters[0] <= cluster_t'(cluster0);
                        r_clusters[1] <= cluster_t'(cluster1);
                        r_clusters[2] <= cluster_t'(cluster2);
                        r_clusters[3] <= cluster_t'(cluster3);
                        r_clusters[4] <= cluster_t'(cluster4);
                        r_clusters[5] <= cluster_t'(cluster5);
                        r_clusters[6] <= cluster_t'(cluster6);
                        r_clusters[7] <= cluster_t'(cluster7);
                        r_overflow    <= overflow_in;
                        r_map         <= '0;
                        r_vfat2       <= '0;
                        r_n           <= '0;
                        r_range_err   <= 1'b0;
                        r_k           <= '0;
                    end
                end
                DECODE: begin
                    r_map   <= w_next_map;
                    r_vfat2 <= w_next_vfat2;
                    if (w_valid)   r_n         <= r_n + 4'd1;
                    if (w_overrun) r_range_err <= 1'b1;
                    r_k <= r_k + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready        = (r_state == IDLE);
    assign out_valid       = (r_state == DONE);
    assign sbits_out       = r_map;
    assign vfat2_sbits_out = r_vfat2;
    assign n_clusters      = r_n;
    assign overflow_out    = r_overflow;
    assign range_err       = r_range_err;

endmodule

// File: tb/tb_cluster_unpacker.sv
// Self-checking bench: behavioural strip-map model, per-cycle compare, directed and random frames.
module tb_cluster_unpacker;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [13:0]   din [8];
    logic          overflow_in;
    logic          out_valid;
    logic          out_ready;
    logic [1535:0] sbits_out;
    logic [191:0]  vfat2_sbits_out;
    logic [3:0]    n_clusters;
    logic          overflow_out;
    logic          range_err;

    int vectors     = 0;
    int miscompares = 0;

    // Expected frame results.
    logic [13:0]   cl [8];
    logic [1535:0] exp_map;
    logic [191:0]  exp_vf;
    int            exp_n;
    logic          exp_re;
    logic          exp_ov;

    always #5 clk = ~clk;

    cluster_unpacker dut (
        .clock4x         (clk),
        .global_reset_n  (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .cluster0        (din[0]),
        .cluster1        (din[1]),
        .cluster2        (din[2]),
        .cluster3        (din[3]),
        .cluster4        (din[4]),
        .cluster5        (din[5]),
        .cluster6        (din[6]),
        .cluster7        (din[7]),
        .overflow_in     (overflow_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sbits_out       (sbits_out),
        .vfat2_sbits_out (vfat2_sbits_out),
        .n_clusters      (n_clusters),
        .overflow_out    (overflow_out),
        .range_err       (range_err)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_map(input string name, input logic [1535:0] act, input logic [1535:0] exp);
        int first;
        int ndiff;
        vectors++;
        if (act !== exp) begin
            miscompares++;
            first = -1;
            ndiff = 0;
            for (int i = 0; i < 1536; i++) begin
                if (act[i] !== exp[i]) begin
                    ndiff++;
                    if (first < 0) first = i;
                end
            end
            $display("FAIL %s: got bit[%0d]=%b expected %b (%0d bits differ) at %0t",
                     name, first, act[first], exp[first], ndiff, $time);
        end
    endtask

    // Strip map straight from the cluster definition: every strip addr..addr+size
    // of a valid cluster, anything past 1535 dropped and reported.
    task automatic build_model();
        int a;
        int s;
        exp_map = '0;
        exp_vf  = '0;
        exp_n   = 0;
        exp_re  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            a = int'(cl[c][10:0]);
            s = int'(cl[c][13:11]);
            if (a < 1536) begin
                exp_n++;
                for (int j = 0; j <= s; j++) begin
                    if (a + j < 1536) exp_map[a + j] = 1'b1;
                    else              exp_re = 1'b1;
                end
            end
        end
        for (int v = 0; v < 192; v++) exp_vf[v] = |exp_map[v*8 +: 8];
    endtask

    task automatic set_invalid();
        for (int i = 0; i < 8; i++) din[i] = 14'h07FF;
    endtask

    function automatic logic [13:0] mk(input int addr, input int size);
        logic [13:0] w;
        w[10:0]  = 11'(addr);
        w[13:11] = 3'(size);
        return w;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accepting edge.
    task automatic accept_frame(input logic ov);
        for (int i = 0; i < 8; i++) cl[i] = din[i];
        exp_ov = ov;
        build_model();
        overflow_in = ov;
        in_valid    = 1'b1;
        chk("in_ready_before_accept", 192'(in_ready), 192'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 7) chk("latency_not_early", 192'(out_valid), 192'(0));
        end
        chk("latency_valid", 192'(out_valid), 192'(1));
    endtask

    task automatic release_frame(input int hold);
        logic [1535:0] snap;
        logic [191:0]  snap_vf;
        snap    = sbits_out;
        snap_vf = vfat2_sbits_out;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 192'(out_valid), 192'(1));
            chk("hold_in_ready", 192'(in_ready), 192'(0));
            chk_map("hold_sbits_stable", sbits_out, snap);
            chk("hold_vfat2_stable", vfat2_sbits_out, snap_vf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_to_idle_in_ready", 192'(in_ready), 192'(1));
        chk("back_to_idle_out_valid", 192'(out_valid), 192'(0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, 192'(in_ready), 192'(1));
        chk({tag, "_out_valid"}, 192'(out_valid), 192'(0));
        chk_map({tag, "_sbits"}, sbits_out, '0);
        chk({tag, "_vfat2"}, vfat2_sbits_out, '0);
        chk({tag, "_n"}, 192'(n_clusters), 192'(0));
        chk({tag, "_range_err"}, 192'(range_err), 192'(0));
        chk({tag, "_overflow"}, 192'(overflow_out), 192'(0));
    endtask

    // Every cycle: handshake exclusivity, and full output check whenever a frame is offered.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ready_valid_exclusive", 192'(in_ready & out_valid), 192'(0));
            if (out_valid === 1'b1) begin
                chk_map("sbits_out", sbits_out, exp_map);
                chk("vfat2_sbits_out", vfat2_sbits_out, exp_vf);
                chk("n_clusters", 192'(n_clusters), 192'(exp_n));
                chk("range_err", 192'(range_err), 192'(exp_re));
                chk("overflow_out", 192'(overflow_out), 192'(exp_ov));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1535:0] t;
        int r;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        overflow_in = 1'b0;
        set_invalid();

        // Reset state.
        @(posedge clk); #1;
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single one-strip cluster.
        set_invalid();
        din[0] = mk(5, 0);
        accept_frame(1'b0);
        chk("model_single_vfat2", exp_vf, 192'(1));
        chk("model_single_n", 192'(exp_n), 192'(1));
        wait_done();
        t = '0; t[5] = 1'b1;
        chk_map("single_sbits", sbits_out, t);
        chk("single_vfat2", vfat2_sbits_out, 192'(1));
        chk("single_n", 192'(n_clusters), 192'(1));
        release_frame(0);

        // Cluster running past the last strip.
        set_invalid();
        din[0] = mk(1534, 3);
        accept_frame(1'b0);
        chk("model_overrun_re", 192'(exp_re), 192'(1));
        wait_done();
        chk("overrun_top_bits", 192'(sbits_out[1535:1534]), 192'(2'b11));
        chk("overrun_bit0", 192'(sbits_out[0]), 192'(0));
        chk("overrun_range_err", 192'(range_err), 192'(1));
        release_frame(1);

        // Overlapping clusters merge, both counted.
        set_invalid();
        din[0] = mk(10, 2);
        din[1] = mk(11, 4);
        accept_frame(1'b0);
        wait_done();
        chk("overlap_bits", 192'(sbits_out[19:8]), 192'(12'h0FC));
        chk("overlap_n", 192'(n_clusters), 192'(2));
        release_frame(0);

        // All clusters invalid.
        set_invalid();
        accept_frame(1'b0);
        wait_done();
        chk_map("empty_sbits", sbits_out, '0);
        chk("empty_n", 192'(n_clusters), 192'(0));
        release_frame(0);

        // Consumer stalls for five cycles; overflow flag carried through.
        set_invalid();
        din[3] = mk(700, 7);
        din[6] = mk(2047, 7);
        accept_frame(1'b1);
        wait_done();
        chk("stall_overflow", 192'(overflow_out), 192'(1));
        release_frame(5);

        // Reset during DECODE at k=3 abandons the frame.
        set_invalid();
        din[0] = mk(100, 7);
        din[5] = mk(1000, 1);
        accept_frame(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_zero_outputs("abandon");
        set_invalid();
        din[2] = mk(64, 0);
        accept_frame(1'b0);
        wait_done();
        chk("after_reset_vfat2", vfat2_sbits_out, 192'(1) << 8);
        release_frame(0);

        // Round trip: VFAT2 bit v=7, b=3 as the packer would emit it (8 strips from v*64+b*8).
        set_invalid();
        din[0] = mk(7 * 64 + 3 * 8, 7);
        accept_frame(1'b0);
        wait_done();
        chk("roundtrip_vfat2", vfat2_sbits_out, 192'(1) << 59);
        release_frame(0);

        // Randomized frames, weighted toward invalid and near-end addresses.
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 3)       din[i] = mk(1536 + int'($urandom_range(0, 511)), int'($urandom_range(0, 7)));
                else if (r == 3) din[i] = mk(1528 + int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                else             din[i] = mk(int'($urandom_range(0, 1535)), int'($urandom_range(0, 7)));
            end
            accept_frame(1'($urandom_range(0, 1)));
            wait_done();
            release_frame(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
